multi_update_counter: RTL

- Multi-channel, programmable successor to the single item-memory address counter.
- NumChannels independent address generators, each with its own valid/ready handshake and latched configuration: base address, stride, count length, mode (WRAP or STOP).
- Feeds parallel item-memory lookups in the data formatter; one channel per lookup port.
- Adds explicit start/done sequencing, last-beat flag and programmable stride; the older counter is fixed stride 1, base 0, wrap-only.

---
 rtl/multi_update_counter_pkg.sv | 20 ++
 rtl/update_counter_channel.sv | 104 ++++++++++
 rtl/multi_update_counter.sv | 51 +++++
 3 files changed

// File: rtl/multi_update_counter_pkg.sv
// Shared types for the multi-channel item-memory address counter:
// run mode and per-channel FSM state encodings.
package multi_update_counter_pkg;

    localparam int DefNumChannels  = 4;
    localparam int DefCounterWidth = 32;
    localparam int DefNumTotIm     = 1024;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_STOP = 1'b1
    } cnt_mode_e;

    typedef enum logic [1:0] {
        CNT_IDLE = 2'd0,
        CNT_RUN  = 2'd1,
        CNT_DONE = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/update_counter_channel.sv
// One address-generator channel: latched config, IDLE/RUN/DONE FSM and
// address/beat datapath.
module update_counter_channel
    import multi_update_counter_pkg::*;
#(
    parameter int CounterWidth = DefCounterWidth,
    parameter int ImAddrWidth  = $clog2(DefNumTotIm)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    clr_i,
    input  logic                    mode_i,
    input  logic [ImAddrWidth-1:0]  base_addr_i,
    input  logic [ImAddrWidth-1:0]  stride_i,
    input  logic [CounterWidth-1:0] max_count_i,
    output logic [ImAddrWidth-1:0]  addr_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output logic                    last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [1:0]              state_o
);

    cnt_state_e              state_q, state_n;
    cnt_mode_e               mode_q, mode_n;
    logic [ImAddrWidth-1:0]  addr_q, addr_n;
    logic [ImAddrWidth-1:0]  base_q, base_n;
    logic [ImAddrWidth-1:0]  stride_q, stride_n;
    logic [CounterWidth-1:0] max_q, max_n;
    logic [CounterWidth-1:0] count_q, count_n;
    logic                    start_ok;
    logic                    beat;
    logic                    at_last;

    // Handshake: a beat is accepted when addr_valid_o && addr_ready_i on a
    // rising edge; valid depends only on registered state, addr is held
    // stable while valid && !ready.
    assign start_ok = start_i && (max_count_i != '0);
    assign beat     = (state_q == CNT_RUN) && addr_ready_i;
    assign at_last  = (count_q == max_q - CounterWidth'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= CNT_IDLE;
            mode_q   <= CNT_WRAP;
            addr_q   <= '0;
            base_q   <= '0;
            stride_q <= '0;
            max_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_n;
            mode_q   <= mode_n;
            addr_q   <= addr_n;
            base_q   <= base_n;
            stride_q <= stride_n;
            max_q    <= max_n;
            count_q  <= count_n;
        end
    end

    // Priority: clear beats start beats handshake advance; a beat accepted
    // alongside clr/start is consumed without advancing.
    always_comb begin
        state_n  = state_q;
        mode_n   = mode_q;
        addr_n   = addr_q;
        base_n   = base_q;
        stride_n = stride_q;
        max_n    = max_q;
        count_n  = count_q;
        if (clr_i) begin
            state_n = CNT_IDLE;
        end else if (start_ok) begin
            state_n  = CNT_RUN;
            mode_n   = cnt_mode_e'(mode_i);
            base_n   = base_addr_i;
            stride_n = stride_i;
            max_n    = max_count_i;
            addr_n   = base_addr_i;
            count_n  = '0;
        end else if (beat) begin
            if (!at_last) begin
                count_n = count_q + CounterWidth'(1);
                addr_n  = addr_q + stride_q;
            end else if (mode_q == CNT_WRAP) begin
                count_n = '0;
                addr_n  = base_q;
            end else begin
                state_n = CNT_DONE;
            end
        end
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = (state_q == CNT_RUN);
    assign last_o       = (state_q == CNT_RUN) && at_last;
    assign busy_o       = (state_q == CNT_RUN);
    assign done_o       = (state_q == CNT_DONE);
    assign state_o      = state_q;

endmodule

// File: rtl/multi_update_counter.sv
// NumChannels independent address generators feeding parallel item-memory
// lookups; each channel owns a slice of the flattened port arrays.
module multi_update_counter
    import multi_update_counter_pkg::*;
#(
    parameter int NumChannels  = DefNumChannels,
    parameter int CounterWidth = DefCounterWidth,
    parameter int NumTotIm     = DefNumTotIm,
    parameter int ImAddrWidth  = $clog2(NumTotIm)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumChannels-1:0]              start_i,
    input  logic [NumChannels-1:0]              clr_i,
    input  logic [NumChannels-1:0]              mode_i,
    input  logic [NumChannels*ImAddrWidth-1:0]  base_addr_i,
    input  logic [NumChannels*ImAddrWidth-1:0]  stride_i,
    input  logic [NumChannels*CounterWidth-1:0] max_count_i,
    output logic [NumChannels*ImAddrWidth-1:0]  addr_o,
    output logic [NumChannels-1:0]              addr_valid_o,
    input  logic [NumChannels-1:0]              addr_ready_i,
    output logic [NumChannels-1:0]              last_o,
    output logic [NumChannels-1:0]              busy_o,
    output logic [NumChannels-1:0]              done_o,
    output logic [NumChannels*2-1:0]            state_o
);

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        update_counter_channel #(
            .CounterWidth (CounterWidth),
            .ImAddrWidth  (ImAddrWidth)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .start_i      (start_i[c]),
            .clr_i        (clr_i[c]),
            .mode_i       (mode_i[c]),
            .base_addr_i  (base_addr_i[c*ImAddrWidth +: ImAddrWidth]),
            .stride_i     (stride_i[c*ImAddrWidth +: ImAddrWidth]),
            .max_count_i  (max_count_i[c*CounterWidth +: CounterWidth]),
            .addr_o       (addr_o[c*ImAddrWidth +: ImAddrWidth]),
            .addr_valid_o (addr_valid_o[c]),
            .addr_ready_i (addr_ready_i[c]),
            .last_o       (last_o[c]),
            .busy_o       (busy_o[c]),
            .done_o       (done_o[c]),
            .state_o      (state_o[c*2 +: 2])
        );
    end

endmodule
